// File: rtl/mac_psum_accum.sv
// Partial-sum accumulator: folds per-group MAC pass results over npass passes, adds bias, saturates.
// Latency 1 cycle from final pass to out_valid; a second finished tile parks in acc (WAIT_OUT) and drops input.
module mac_psum_accum #(
  parameter int MAX_GROUPS = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PASS_BITS  = 8,
  localparam int ACC_W     = 4 * DATA_WIDTH,
  localparam int NG_W      = $clog2(MAX_GROUPS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  input  logic [PASS_BITS-1:0]          cfg_num_passes,
  input  logic [MAX_GROUPS*ACC_W-1:0]   cfg_bias,
  input  logic                          in_valid,
  input  logic [MAX_GROUPS*ACC_W-1:0]   in_data,
  input  logic [NG_W-1:0]               in_num_groups,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_GROUPS*ACC_W-1:0]   out_data,
  output logic [NG_W-1:0]               out_num_groups,
  output logic                          busy,
  output logic                          drop_err,
  output logic                          sat_err
);

  typedef logic [MAX_GROUPS-1:0][ACC_W-1:0] lanes_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [PASS_BITS-1:0] pass_cnt_q, pass_cnt_d;
  logic [PASS_BITS-1:0] npass_q, npass_d;
  lanes_t               bias_q, bias_d;
  logic [NG_W-1:0]      ngroups_q, ngroups_d;
  lanes_t               acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  lanes_t               out_data_q, out_data_d;
  logic [NG_W-1:0]      out_ngroups_q, out_ngroups_d;
  logic                 drop_err_q, drop_err_d;
  logic                 sat_err_q, sat_err_d;

  lanes_t               in_lanes;
  lanes_t               cfg_bias_lanes;
  lanes_t               eff_bias;
  lanes_t               sum_lanes;
  logic [MAX_GROUPS-1:0] lane_sat;
  logic [PASS_BITS-1:0] cfg_npass;
  logic [PASS_BITS-1:0] eff_npass;
  logic [NG_W-1:0]      eff_ngroups;
  logic                 cfg_take;
  logic                 first_pass;
  logic                 last_pass;
  logic                 out_free;

  assign in_lanes       = in_data;
  assign cfg_bias_lanes = cfg_bias;

  // A config arriving with pass 0 governs that same pass, so the lane math uses the effective values.
  assign cfg_take    = (state_q == S_ACCUM) && cfg_valid && (pass_cnt_q == '0);
  assign cfg_npass   = (cfg_num_passes == '0) ? PASS_BITS'(1) : cfg_num_passes;
  assign eff_npass   = cfg_take ? cfg_npass : npass_q;
  assign eff_bias    = cfg_take ? cfg_bias_lanes : bias_q;
  assign first_pass  = (pass_cnt_q == '0);
  assign eff_ngroups = first_pass ? in_num_groups : ngroups_q;
  assign last_pass   = (pass_cnt_q == eff_npass - PASS_BITS'(1));
  assign out_free    = !out_valid_q || out_ready;

  for (genvar g = 0; g < MAX_GROUPS; g++) begin : g_lane
    localparam logic [NG_W-1:0] LANE = NG_W'(g);
    logic             act;
    logic             ovf;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   wide;

    assign act  = (LANE < eff_ngroups);
    assign base = first_pass ? eff_bias[g] : acc_q[g];
    assign wide = {base[ACC_W-1], base} + {in_lanes[g][ACC_W-1], in_lanes[g]};
    assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

    assign sum_lanes[g] = !act ? '0 :
                          ovf  ? (wide[ACC_W] ? SAT_MIN : SAT_MAX) :
                                 wide[ACC_W-1:0];
    assign lane_sat[g]  = act && ovf;
  end

  always_comb begin
    state_d       = state_q;
    pass_cnt_d    = pass_cnt_q;
    npass_d       = npass_q;
    bias_d        = bias_q;
    ngroups_d     = ngroups_q;
    acc_d         = acc_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_ngroups_d = out_ngroups_q;
    drop_err_d    = drop_err_q;
    sat_err_d     = sat_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          drop_err_d = 1'b1;
        end
        if (cfg_valid) begin
          npass_d    = cfg_npass;
          bias_d     = cfg_bias_lanes;
          pass_cnt_d = '0;
          state_d    = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (cfg_take) begin
          npass_d = cfg_npass;
          bias_d  = cfg_bias_lanes;
        end
        if (in_valid) begin
          if (first_pass) begin
            ngroups_d = in_num_groups;
          end
          if (|lane_sat) begin
            sat_err_d = 1'b1;
          end
          if (last_pass) begin
            pass_cnt_d = '0;
            if (out_free) begin
              out_data_d    = sum_lanes;
              out_ngroups_d = eff_ngroups;
              out_valid_d   = 1'b1;
            end else begin
              acc_d   = sum_lanes;
              state_d = S_WAIT;
            end
          end else begin
            acc_d      = sum_lanes;
            pass_cnt_d = pass_cnt_q + PASS_BITS'(1);
          end
        end
      end

      S_WAIT: begin
        // The transfer cycle still drops input: acc is busy holding the parked tile.
        if (in_valid) begin
          drop_err_d = 1'b1;
        end
        if (out_free) begin
          out_data_d    = acc_q;
          out_ngroups_d = ngroups_q;
          out_valid_d   = 1'b1;
          pass_cnt_d    = '0;
          state_d       = S_ACCUM;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pass_cnt_q    <= '0;
      npass_q       <= PASS_BITS'(1);
      bias_q        <= '0;
      ngroups_q     <= '0;
      acc_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_ngroups_q <= '0;
      drop_err_q    <= 1'b0;
      sat_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pass_cnt_q    <= pass_cnt_d;
      npass_q       <= npass_d;
      bias_q        <= bias_d;
      ngroups_q     <= ngroups_d;
      acc_q         <= acc_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_ngroups_q <= out_ngroups_d;
      drop_err_q    <= drop_err_d;
      sat_err_q     <= sat_err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_num_groups = out_ngroups_q;
  assign busy           = (pass_cnt_q != '0) || (state_q == S_WAIT);
  assign drop_err       = drop_err_q;
  assign sat_err        = sat_err_q;

endmodule

// File: tb/tb_mac_psum_accum.sv
// Bench for mac_psum_accum: directed cases plus randomized traffic against a tile-level queue model.
module tb_mac_psum_accum;
  localparam int G   = 8;
  localparam int W   = 32;
  localparam int NGW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [7:0]       cfg_num_passes;
  logic [G*W-1:0]   cfg_bias;
  logic             in_valid;
  logic [G*W-1:0]   in_data;
  logic [NGW-1:0]   in_num_groups;
  logic             out_valid;
  logic             out_ready;
  logic [G*W-1:0]   out_data;
  logic [NGW-1:0]   out_num_groups;
  logic             busy;
  logic             drop_err;
  logic             sat_err;

  mac_psum_accum dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_num_passes (cfg_num_passes),
    .cfg_bias       (cfg_bias),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_num_groups  (in_num_groups),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_num_groups (out_num_groups),
    .busy           (busy),
    .drop_err       (drop_err),
    .sat_err        (sat_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [G*W-1:0] got, input logic [G*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Tile-level model: finished tiles queue up (at most one in the output register, one parked).
  typedef struct {
    logic [G*W-1:0] data;
    logic [NGW-1:0] ng;
  } res_t;

  res_t        pend[$];
  bit          m_cfgd;
  int          m_pass;
  int          m_npass;
  int          m_ng;
  bit          m_drop;
  bit          m_sat;
  logic [W-1:0] m_bias [G];
  logic [W-1:0] m_acc  [G];

  function automatic logic [W-1:0] sat32(input longint v, inout bit s);
    if (v > 64'sd2147483647) begin
      s = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (v < -64'sd2147483648) begin
      s = 1'b1;
      return 32'h8000_0000;
    end
    return v[W-1:0];
  endfunction

  task automatic take_cfg();
    m_npass = (cfg_num_passes == 0) ? 1 : int'(cfg_num_passes);
    for (int g = 0; g < G; g++) m_bias[g] = cfg_bias[g*W +: W];
  endtask

  task automatic model_edge();
    bit   consumed;
    bit   done;
    res_t r;
    longint base;
    done = 1'b0;
    if (rst) begin
      m_cfgd = 1'b0; m_pass = 0; m_npass = 1; m_ng = 0;
      m_drop = 1'b0; m_sat = 1'b0;
      pend.delete();
      return;
    end
    consumed = (pend.size() > 0) && out_ready;
    if (!m_cfgd) begin
      if (in_valid) m_drop = 1'b1;
      if (cfg_valid) begin
        m_cfgd = 1'b1;
        take_cfg();
        m_pass = 0;
      end
    end else if (pend.size() == 2) begin
      if (in_valid) m_drop = 1'b1;
    end else begin
      if (cfg_valid && m_pass == 0) take_cfg();
      if (in_valid) begin
        if (m_pass == 0) m_ng = int'(in_num_groups);
        for (int g = 0; g < G; g++) begin
          if (g < m_ng) begin
            base = (m_pass == 0) ? longint'($signed(m_bias[g])) : longint'($signed(m_acc[g]));
            m_acc[g] = sat32(base + longint'($signed(in_data[g*W +: W])), m_sat);
          end else begin
            m_acc[g] = '0;
          end
        end
        m_pass++;
        if (m_pass == m_npass) begin
          m_pass = 0;
          done = 1'b1;
        end
      end
    end
    if (consumed) void'(pend.pop_front());
    if (done) begin
      for (int g = 0; g < G; g++) r.data[g*W +: W] = m_acc[g];
      r.ng = NGW'(m_ng);
      pend.push_back(r);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", G*W'(out_valid), G*W'(pend.size() > 0));
    if (pend.size() > 0) begin
      chk("out_data", out_data, pend[0].data);
      chk("out_num_groups", G*W'(out_num_groups), G*W'(pend[0].ng));
    end
    chk("busy", G*W'(busy), G*W'((m_pass != 0) || (pend.size() == 2)));
    chk("drop_err", G*W'(drop_err), G*W'(m_drop));
    chk("sat_err", G*W'(sat_err), G*W'(m_sat));
  endtask

  task automatic step(input bit cv, input logic [7:0] np, input logic [G*W-1:0] b,
                      input bit iv, input logic [G*W-1:0] d, input logic [NGW-1:0] ng,
                      input bit rdy);
    cfg_valid      = cv;
    cfg_num_passes = np;
    cfg_bias       = b;
    in_valid       = iv;
    in_data        = d;
    in_num_groups  = ng;
    out_ready      = rdy;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [G*W-1:0] rep(input logic [W-1:0] v);
    logic [G*W-1:0] x;
    for (int g = 0; g < G; g++) x[g*W +: W] = v;
    return x;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, '0, 0, '0, 0, 0);
    step(0, 0, '0, 0, '0, 0, 0);
    rst = 1'b0;
    chk("rst_out_data", out_data, '0);
    chk("rst_out_ng", G*W'(out_num_groups), '0);
    chk("rst_out_valid", G*W'(out_valid), '0);
    chk("rst_busy", G*W'(busy), '0);
  endtask

  function automatic logic [W-1:0] rnd_lane();
    case ($urandom_range(0, 4))
      0: return W'($urandom);
      1: return 32'h7FFF_FF00 + W'($urandom_range(0, 255));
      2: return 32'h8000_0000 + W'($urandom_range(0, 255));
      default: return W'($urandom_range(0, 2000)) - 32'd1000;
    endcase
  endfunction

  function automatic logic [G*W-1:0] rnd_vec();
    logic [G*W-1:0] x;
    for (int g = 0; g < G; g++) x[g*W +: W] = rnd_lane();
    return x;
  endfunction

  initial begin
    logic [G*W-1:0] e;
    logic [G*W-1:0] d;

    rst = 1'b1; cfg_valid = 0; cfg_num_passes = 0; cfg_bias = '0;
    in_valid = 0; in_data = '0; in_num_groups = 0; out_ready = 0;
    do_reset();

    // Single pass with bias 10, lanes g*100.
    step(1, 1, rep(32'd10), 0, '0, 0, 1);
    for (int g = 0; g < G; g++) d[g*W +: W] = W'(g * 100);
    step(0, 0, '0, 1, d, 4'd8, 1);
    for (int g = 0; g < G; g++) e[g*W +: W] = W'(10 + 100 * g);
    chk("t1_valid", G*W'(out_valid), G*W'(1));
    chk("t1_data", out_data, e);
    chk("t1_busy", G*W'(busy), '0);

    // Four passes over three active groups.
    step(1, 4, '0, 0, '0, 0, 1);
    d = rnd_vec();
    d[0 +: W] = 32'd5; d[W +: W] = -32'sd7; d[2*W +: W] = 32'd1000;
    for (int p = 0; p < 4; p++) begin
      step(0, 0, '0, 1, d, 4'd3, 1);
      if (p < 3) chk("t2_early_valid", G*W'(out_valid), '0);
    end
    e = '0; e[0 +: W] = 32'd20; e[W +: W] = -32'sd28; e[2*W +: W] = 32'd4000;
    chk("t2_data", out_data, e);
    chk("t2_ng", G*W'(out_num_groups), G*W'(3));

    // Saturation both directions.
    step(1, 2, rep(32'h7FFF_FFF0), 0, '0, 0, 1);
    step(0, 0, '0, 1, rep(32'h100), 4'd8, 1);
    step(0, 0, '0, 1, rep(32'h100), 4'd8, 1);
    chk("t3_pos", out_data, rep(32'h7FFF_FFFF));
    chk("t3_sat", G*W'(sat_err), G*W'(1));
    step(1, 1, rep(32'h8000_0000), 0, '0, 0, 1);
    step(0, 0, '0, 1, rep(32'hFFFF_FFFF), 4'd8, 1);
    chk("t3_neg", out_data, rep(32'h8000_0000));
    step(0, 0, '0, 0, '0, 0, 1);

    // Backpressure: A held, B parked, C dropped.
    step(1, 1, '0, 0, '0, 0, 1);
    step(0, 0, '0, 1, rep(32'd1), 4'd8, 0);
    chk("t4_a_valid", G*W'(out_valid), G*W'(1));
    step(0, 0, '0, 1, rep(32'd2), 4'd8, 0);
    chk("t4_b_busy", G*W'(busy), G*W'(1));
    chk("t4_a_held", out_data, rep(32'd1));
    chk("t4_no_drop_yet", G*W'(drop_err), '0);
    step(0, 0, '0, 1, rep(32'd3), 4'd8, 0);
    chk("t4_drop", G*W'(drop_err), G*W'(1));
    step(0, 0, '0, 0, '0, 0, 1);
    chk("t4_b_loaded", out_data, rep(32'd2));
    step(0, 0, '0, 0, '0, 0, 1);
    chk("t4_drained", G*W'(out_valid), '0);

    // Config together with pass 0 applies; config at pass 1 ignored.
    step(1, 2, '0, 1, rep(32'd7), 4'd8, 1);
    chk("t5_not_done", G*W'(out_valid), '0);
    step(1, 1, rep(32'd100), 1, rep(32'd7), 4'd8, 1);
    chk("t5_done", out_data, rep(32'd14));

    // Reset mid-tile, then input before config.
    step(1, 4, '0, 0, '0, 0, 1);
    step(0, 0, '0, 1, rep(32'd9), 4'd8, 1);
    step(0, 0, '0, 1, rep(32'd9), 4'd8, 1);
    chk("t6_busy_mid", G*W'(busy), G*W'(1));
    do_reset();
    chk("t6_drop_clr", G*W'(drop_err), '0);
    chk("t6_sat_clr", G*W'(sat_err), '0);
    step(0, 0, '0, 1, rep(32'd9), 4'd8, 1);
    chk("t6_idle_drop", G*W'(drop_err), G*W'(1));
    chk("t6_idle_novalid", G*W'(out_valid), '0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      step(($urandom_range(0, 5) == 0), 8'($urandom_range(0, 5)), rnd_vec(),
           ($urandom_range(0, 9) < 7), rnd_vec(), NGW'($urandom_range(0, 8)),
           ($urandom_range(0, 9) < 6));
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_psum_accum.md
# mac_psum_accum

Partial-sum accumulator directly downstream of the grouped MAC array. It sums the per-group 32-bit MAC results over a configured number of passes, when a dot product is longer than the 64 MAC lanes. It adds a per-group bias on the first pass and saturates to signed 32 bits. Each finished tile is presented on a valid/ready output register, which lets the accumulator start the next tile while the previous result drains.

## Interface
- MAX_GROUPS, 8, number of independent MAC groups/lanes in the result vector
- DATA_WIDTH, 8, MAC operand width; lane width ACC_W = 4*DATA_WIDTH (32)
- PASS_BITS, 8, width of the pass-count configuration

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config strobe; accepted only at a tile boundary (see Operation)
- cfg_num_passes  in  PASS_BITS  MAC passes per tile; 0 treated as 1
- cfg_bias  in  MAX_GROUPS*ACC_W  signed per-group bias, lane g at [g*ACC_W +: ACC_W]
- in_valid  in  1  one MAC pass result present (connects to MAC valid_out); no backpressure possible
- in_data  in  MAX_GROUPS*ACC_W  signed per-group pass sums (MAC mac_out)
- in_num_groups  in  $clog2(MAX_GROUPS+1)  active groups (MAC num_groups_o)
- out_valid  out  1  tile result held
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  MAX_GROUPS*ACC_W  signed accumulated + biased result; lanes >= out_num_groups are 0
- out_num_groups  out  $clog2(MAX_GROUPS+1)  group count latched at pass 0 of the tile
- busy  out  1  pass_cnt != 0 or state WAIT_OUT
- drop_err  out  1  sticky: an in_valid pass was discarded
- sat_err  out  1  sticky: any lane saturated

## Operation
- Per-lane state is acc[g] (ACC_W signed). Control state is IDLE/ACCUM/WAIT_OUT, plus pass_cnt (PASS_BITS), latched npass, bias, and ngroups.
- IDLE (after reset): in_valid is dropped and sets drop_err. cfg_valid latches npass = max(cfg_num_passes,1) and bias, then goes to ACCUM with pass_cnt=0.
- ACCUM, cfg_valid with pass_cnt==0: reconfigures. If cfg_valid and in_valid arrive in the same cycle, the new config applies to that pass. cfg_valid with pass_cnt!=0 is ignored.
- ACCUM, in_valid:
  - Pass 0: acc[g] = sat(bias[g] + in[g]), and in_num_groups is latched.
  - Later passes: acc[g] = sat(acc[g] + in[g]).
  - pass_cnt increments.
- Final pass (pass_cnt == npass-1):
  - Compute the final value combinationally.
  - If the output register is free (out_valid==0, or out_valid&out_ready this cycle), load out_data/out_num_groups, set out_valid, set pass_cnt=0, and stay in ACCUM.
  - Otherwise store the final value in acc and go to WAIT_OUT.
- WAIT_OUT:
  - When the output register frees, transfer acc to it, then go to ACCUM with pass_cnt=0.
  - in_valid in WAIT_OUT is dropped and sets drop_err, including in the transfer cycle.
  - cfg_valid in WAIT_OUT is ignored.
- Saturation: compute the sum in ACC_W+1 bits, then clamp to [-2^31, 2^31-1]. Any clamp on an active lane sets sat_err.
- Inactive lanes (g >= latched ngroups) are forced to 0 and never set sat_err.
- out_valid falls on the handshake unless a new result loads the same cycle; in that case out_valid stays 1 with the new data.
- rst mid-tile: all state clears to IDLE, and the partial tile is discarded.

## Timing
- Reset values: out_valid=0, out_data=0, out_num_groups=0, busy=0, drop_err=0, sat_err=0, state=IDLE, pass_cnt=0.
- Latency: final in_valid at edge N gives out_valid=1 after edge N (1 cycle) when the output register is free.
- Throughput: one pass per cycle; npass=1 streams one result per cycle under continuous out_ready.
- out_data and out_num_groups are stable while out_valid & !out_ready.
- drop_err and sat_err clear only on rst.

## Test plan
- Reset, cfg npass=1, bias all 10, ngroups=8, in lanes g=g*100, out_ready=1 -> next cycle out_valid=1, lane g = 10+100g, busy=0.
- npass=4, bias=0, ngroups=3, in lanes = {5,-7,1000,...} each pass -> one out_valid after pass 4 with {20,-28,4000}, lanes 3..7 = 0, out_num_groups=3.
- Saturation: npass=2, bias=0x7FFFFFF0, in=0x100 -> lane = 0x7FFFFFFF, sat_err=1. Negative case: bias=-2^31, in=-1 -> 0x80000000.
- Backpressure, npass=1, out_ready=0:
  - Pass A -> out_valid.
  - Pass B -> WAIT_OUT, busy=1.
  - Pass C -> dropped, drop_err=1.
  - out_ready=1 -> A accepted, B loaded next cycle.
- Same-cycle cfg_valid (npass=2) and in_valid at pass_cnt==0 -> new npass is used; output after the 2nd pass. cfg_valid at pass_cnt=1 is ignored.
- rst asserted after pass 2 of 4 -> all outputs 0 and state IDLE. in_valid before cfg -> dropped, drop_err=1.
